data_memory_dump_controller: RTL

Debug-unit sequencer that reads the data memory's debug read port one byte at a time, from address 0 to MEMORY_DEPTH-1, and streams each byte to the UART transmitter over a start/done handshake. It sits between the debug unit's command FSM, which issues a one-cycle start and waits for done, and the data memory's debug port signals (enable, read enable, read address, byte data). It is the only driver of those debug port signals while a dump is in progress.

---
 rtl/data_memory_dump_controller.sv | 106 ++++++++++
 1 files changed

// File: rtl/data_memory_dump_controller.sv
// Debug-unit sequencer: reads every data-memory entry over the debug port and
// streams each byte to the UART transmitter using a start/done handshake.
module data_memory_dump_controller #(
    parameter int MEMORY_WIDTH = 8,
    parameter int MEMORY_DEPTH = 128,
    parameter int NB_ADDR      = 7
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [MEMORY_WIDTH-1:0] i_byte_data,
    input  logic                    i_tx_done,
    output logic                    o_mem_enable,
    output logic                    o_read_enable,
    output logic [NB_ADDR-1:0]      o_read_address,
    output logic [MEMORY_WIDTH-1:0] o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_busy,
    output logic                    o_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);

    state_t                    state_q, state_d;
    logic [NB_ADDR-1:0]        addr_q, addr_d;
    logic [MEMORY_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                      mem_en_q;
    logic                      tx_start_q;
    logic                      busy_q;
    logic                      done_q;

    // Next-state, address counter and byte capture logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_READ;
                    addr_d  = {NB_ADDR{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                // Memory output is registered, so the byte is valid one cycle after READ.
                tx_data_d = i_byte_data;
                state_d   = ST_SEND;
            end
            ST_SEND: state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (!i_tx_done) begin
                    state_d = ST_WAIT_TX;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + NB_ADDR'(1);
                    state_d = ST_READ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and outputs; outputs are registered from the next state.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= {NB_ADDR{1'b0}};
            tx_data_q  <= {MEMORY_WIDTH{1'b0}};
            mem_en_q   <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            mem_en_q   <= (state_d == ST_READ);
            tx_start_q <= (state_d == ST_SEND);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign o_mem_enable   = mem_en_q;
    assign o_read_enable  = mem_en_q;
    assign o_read_address = addr_q;
    assign o_tx_data      = tx_data_q;
    assign o_tx_start     = tx_start_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule
